mii_store_forward_bridge: RTL and testbench
===========================================

Name: mii_store_forward_bridge

Overview:
- 10/100 MII store-and-forward repeater.
- Receives nibble frames from a PHY MII RX interface, strips the preamble and SFD, and assembles the payload into bytes.
- Stores each complete frame in an internal FIFO, then retransmits it on the MII TX interface with a regenerated preamble and SFD.
- Sits between the PHY model and downstream MAC logic. Exposes the last received byte and the byte currently being transmitted for observation.

Parameters:
- ADDR_W, 11, FIFO address width; depth = 2**ADDR_W entries of 9 bits (data[7:0] plus last flag).
- PRE_NIB, 15, number of 0x5 preamble nibbles transmitted before the SFD nibble 0xD.
- IFG_NIB, 24, minimum idle nibble periods between transmitted frames (96 bit times).

Ports:
- clk  in  1  system clock; must be at least 4x phy_rx_clk and phy_tx_clk.
- reset  in  1  asynchronous, active-low reset.
- phy_rx_clk  in  1  MII RX clock, treated as data: 2-flop synchronised, rising edge detected in clk domain.
- phy_rx_dv  in  1  MII receive data valid, sampled on detected phy_rx_clk rising edges.
- phy_rxd  in  4  MII receive nibble.
- phy_tx_clk  in  1  MII TX clock, treated as data: 2-flop synchronised, rising edge detected.
- phy_tx_en  out  1  MII transmit enable.
- phy_txd  out  4  MII transmit nibble.
- data_from_phy  out  8  last byte assembled from RX and written toward the FIFO; held until the next byte.
- data_from_buff  out  8  byte most recently read from the FIFO for transmission; held.

Behaviour:
- Clocking: one clock domain (clk). phy_rx_dv and phy_rxd are also passed through 2-flop synchronisers, delayed to stay aligned with the synchronised clock.
- An "RX tick" is one clk cycle where synchronised phy_rx_clk goes 0->1; a "TX tick" is the same for phy_tx_clk.
- Reset (reset=0): all outputs 0; FIFO pointers, frame counter and all FSMs cleared; RX FSM in IDLE, TX FSM in IDLE.
- RX FSM, evaluated on RX ticks:
  - IDLE: on dv=1 go to PREAMBLE.
  - PREAMBLE: nibble 0x5 stays; nibble 0xD goes to DATA (SFD found); any other nibble goes to DROP; dv=0 returns to IDLE.
  - DATA: nibbles are collected low nibble first. Each second nibble forms byte {second,first}, which is written at the tentative write pointer with last=0 and copied to data_from_phy.
  - End of frame in DATA (dv=0): the last written entry's last flag is set to 1, the committed write pointer is set to the tentative pointer, and the frame counter is incremented. An odd trailing nibble is discarded.
  - Frames with zero data bytes are ignored.
  - DROP: wait for dv=0, then go to IDLE.
- Overflow:
  - If a byte must be written while the FIFO is full (tentative pointer + 1 == read pointer), the tentative pointer rolls back to the committed pointer and RX enters DROP. The whole frame is discarded; no partial frame ever becomes visible.
  - data_from_phy still shows the bytes received before the drop.
- FIFO: single clk domain, registered read (1-cycle latency). The read side only sees committed data.
- TX FSM, changes outputs only on TX ticks:
  - IDLE: when frame counter > 0 and the IFG is satisfied, go to PREAMBLE.
  - PREAMBLE: drive phy_tx_en=1 with txd=0x5 for PRE_NIB ticks, then txd=0xD for 1 tick.
  - DATA: read a FIFO entry (prefetch so it is ready before the tick) and copy it to data_from_buff. Drive the low nibble on one tick and the high nibble on the next. Repeat until the entry with last=1 has been fully sent.
  - After the final high nibble: next tick sets phy_tx_en=0 and phy_txd=0, decrements the frame counter and enters IFG.
  - IFG: count IFG_NIB ticks, then go to IDLE.
- Simultaneous commit (RX) and frame completion (TX) in the same clk cycle: the frame counter is unchanged (increment and decrement cancel).
- The frame counter is ADDR_W bits wide and cannot overflow, because frames are at least 1 byte.
- No CRC check or generation: the FCS is forwarded as ordinary data.
- Reset mid-frame: immediate return to reset state; phy_tx_en drops to 0 asynchronously.

Test Plan:
- Frame received as 15x0x5, 0xD, then bytes 12 d1 46 11 10 11 59 ab cd ef 11 22 ab 12 + 100 bytes 0x19 + 4 FCS bytes -> data_from_phy steps through each byte. The TX output then shows phy_tx_en=1, 15x0x5, 0xD, and nibbles 2,1,1,d,... reproducing all 118 bytes exactly, with data_from_buff tracking each byte.
- Two back-to-back frames (second with dest d2345678aabb, 99-byte payload) -> both retransmitted in order, with at least 24 idle TX ticks (phy_tx_en=0) between them.
- Frame whose preamble contains 0x3 before the SFD -> nothing is written and phy_tx_en stays 0.
- Frame with an odd nibble count (2 bytes + 1 nibble) -> exactly 2 bytes retransmitted.
- ADDR_W=4 with a 20-byte frame -> frame dropped and phy_tx_en stays 0. A following 8-byte frame is transmitted correctly.
- reset asserted low mid-transmission -> phy_tx_en=0, phy_txd=0 and data_from_phy=data_from_buff=0 immediately. After release, a new frame is forwarded normally.

Source files
------------

// File: rtl/mii_store_forward_bridge_if.sv
// MII pin bundle between a PHY (or PHY model) and the store-and-forward bridge.
// Latency: none, wires only.
// Backpressure: none; MII is a free-running nibble stream with no ready signal.
//
// Signals: phy_rx_clk/phy_rx_dv/phy_rxd  receive side, driven by the PHY
//          phy_tx_clk                    transmit clock, driven by the PHY
//          phy_tx_en/phy_txd             transmit side, driven by the bridge
interface mii_store_forward_bridge_if;
    logic       phy_rx_clk;
    logic       phy_rx_dv;
    logic [3:0] phy_rxd;
    logic       phy_tx_clk;
    logic       phy_tx_en;
    logic [3:0] phy_txd;

    // PHY side
    modport master (
        output phy_rx_clk, phy_rx_dv, phy_rxd, phy_tx_clk,
        input  phy_tx_en, phy_txd
    );

    // Bridge side
    modport slave (
        input  phy_rx_clk, phy_rx_dv, phy_rxd, phy_tx_clk,
        output phy_tx_en, phy_txd
    );
endinterface

// File: rtl/mii_store_forward_bridge.sv
// 10/100 MII store-and-forward repeater: strips preamble/SFD, buffers whole frames, regenerates preamble/SFD on TX.
// Latency: a frame starts on TX only after its last byte is committed (plus synchroniser and IFG delay).
// Backpressure: none on MII; a frame that does not fit in the FIFO is dropped whole.
//
// Ports: clk            system clock, at least 4x the MII clocks
//        reset          asynchronous active-low reset
//        mii            MII pins (slave modport); MII clocks are sampled as data
//        data_from_phy  last byte assembled from RX, held
//        data_from_buff last byte read from the FIFO for TX, held
module mii_store_forward_bridge #(
    parameter int ADDR_W  = 11,
    parameter int PRE_NIB = 15,
    parameter int IFG_NIB = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    mii_store_forward_bridge_if.slave mii,
    output logic [7:0]                data_from_phy,
    output logic [7:0]                data_from_buff
);
    localparam int                CNT_W    = 8;
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_NIB);
    localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'(IFG_NIB - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_DROP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_PRE, TX_DATA, TX_END, TX_IFG} tx_state_t;

    // Synchronisers. Bit 0 is the first stage; bit 2 of the clock chains is only for edge detect.
    logic [2:0] rx_clk_sync_q, rx_clk_sync_d;
    logic [1:0] rx_dv_sync_q, rx_dv_sync_d;
    logic [3:0] rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d;
    logic [2:0] tx_clk_sync_q, tx_clk_sync_d;

    // RX state
    rx_state_t   rx_state_q, rx_state_d;
    logic [3:0]  nib_lo_q, nib_lo_d;
    logic        nib_phase_q, nib_phase_d;
    logic        rx_any_q, rx_any_d;
    logic [ADDR_W-1:0] wr_tent_q, wr_tent_d;
    logic [ADDR_W-1:0] wr_com_q, wr_com_d;
    logic [7:0]  data_from_phy_q, data_from_phy_d;

    // TX state
    tx_state_t   tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic        tx_hi_q, tx_hi_d;
    logic        cur_last_q, cur_last_d;
    logic        fetch_pend_q, fetch_pend_d;
    logic        tx_en_q, tx_en_d;
    logic [3:0]  txd_q, txd_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  data_from_buff_q, data_from_buff_d;

    logic [ADDR_W-1:0] frame_cnt_q, frame_cnt_d;

    // FIFO storage: {last, data}
    logic [8:0]        mem [0:(1<<ADDR_W)-1];
    logic [8:0]        rd_dat_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [8:0]        mem_wdat;
    logic              rd_en;
    logic              frame_inc, frame_dec;

    logic       rx_tick, tx_tick, rx_dv;
    logic [3:0] rxd;

    always_comb begin
        rx_clk_sync_d = {rx_clk_sync_q[1:0], mii.phy_rx_clk};
        rx_dv_sync_d  = {rx_dv_sync_q[0], mii.phy_rx_dv};
        rxd_s1_d      = mii.phy_rxd;
        rxd_s2_d      = rxd_s1_q;
        tx_clk_sync_d = {tx_clk_sync_q[1:0], mii.phy_tx_clk};
    end

    // dv/rxd second stage lines up with the second stage of the RX clock chain.
    assign rx_tick = rx_clk_sync_q[1] & ~rx_clk_sync_q[2];
    assign tx_tick = tx_clk_sync_q[1] & ~tx_clk_sync_q[2];
    assign rx_dv   = rx_dv_sync_q[1];
    assign rxd     = rxd_s2_q;

    // RX: preamble hunt, nibble pairing and tentative writes.
    always_comb begin
        rx_state_d      = rx_state_q;
        nib_lo_d        = nib_lo_q;
        nib_phase_d     = nib_phase_q;
        rx_any_d        = rx_any_q;
        wr_tent_d       = wr_tent_q;
        wr_com_d        = wr_com_q;
        data_from_phy_d = data_from_phy_q;
        mem_we          = 1'b0;
        mem_waddr       = wr_tent_q;
        mem_wdat        = 9'h000;
        frame_inc       = 1'b0;
        if (rx_tick) begin
            case (rx_state_q)
                RX_IDLE: if (rx_dv) rx_state_d = RX_PRE;
                RX_PRE: begin
                    if (!rx_dv)             rx_state_d = RX_IDLE;
                    else if (rxd == 4'hD) begin
                        rx_state_d  = RX_DATA;
                        nib_phase_d = 1'b0;
                        rx_any_d    = 1'b0;
                    end else if (rxd != 4'h5) rx_state_d = RX_DROP;
                end
                RX_DATA: begin
                    if (!rx_dv) begin
                        // Rewrite the final byte with its last flag, then publish the frame.
                        if (rx_any_q) begin
                            mem_we    = 1'b1;
                            mem_waddr = wr_tent_q - A_ONE;
                            mem_wdat  = {1'b1, data_from_phy_q};
                            wr_com_d  = wr_tent_q;
                            frame_inc = 1'b1;
                        end
                        rx_state_d = RX_IDLE;
                    end else if (!nib_phase_q) begin
                        nib_lo_d    = rxd;
                        nib_phase_d = 1'b1;
                    end else begin
                        nib_phase_d = 1'b0;
                        if (wr_tent_q + A_ONE == rd_ptr_q) begin
                            // Full: forget everything written for this frame.
                            wr_tent_d  = wr_com_q;
                            rx_state_d = RX_DROP;
                        end else begin
                            mem_we          = 1'b1;
                            mem_wdat        = {1'b0, rxd, nib_lo_q};
                            wr_tent_d       = wr_tent_q + A_ONE;
                            data_from_phy_d = {rxd, nib_lo_q};
                            rx_any_d        = 1'b1;
                        end
                    end
                end
                RX_DROP: if (!rx_dv) rx_state_d = RX_IDLE;
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // TX: preamble generation, byte prefetch, nibble serialisation, IFG.
    always_comb begin
        tx_state_d       = tx_state_q;
        tx_cnt_d         = tx_cnt_q;
        tx_hi_d          = tx_hi_q;
        cur_last_d       = cur_last_q;
        fetch_pend_d     = fetch_pend_q;
        tx_en_d          = tx_en_q;
        txd_d            = txd_q;
        rd_ptr_d         = rd_ptr_q;
        data_from_buff_d = data_from_buff_q;
        rd_en            = 1'b0;
        frame_dec        = 1'b0;
        // Read data lands one cycle after the request, well before the next TX tick.
        if (fetch_pend_q) begin
            data_from_buff_d = rd_dat_q[7:0];
            cur_last_d       = rd_dat_q[8];
            fetch_pend_d     = 1'b0;
        end
        if (tx_tick) begin
            case (tx_state_q)
                TX_IDLE: if (frame_cnt_q != '0) begin
                    tx_en_d    = 1'b1;
                    txd_d      = 4'h5;
                    tx_cnt_d   = C_ONE;
                    tx_state_d = TX_PRE;
                end
                TX_PRE: begin
                    if (tx_cnt_q < PRE_LAST) begin
                        txd_d    = 4'h5;
                        tx_cnt_d = tx_cnt_q + C_ONE;
                    end else begin
                        txd_d        = 4'hD;
                        rd_en        = 1'b1;
                        fetch_pend_d = 1'b1;
                        tx_hi_d      = 1'b0;
                        tx_state_d   = TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (!tx_hi_q) begin
                        txd_d   = data_from_buff_q[3:0];
                        tx_hi_d = 1'b1;
                    end else begin
                        txd_d   = data_from_buff_q[7:4];
                        tx_hi_d = 1'b0;
                        if (cur_last_q) begin
                            tx_state_d = TX_END;
                        end else begin
                            rd_en        = 1'b1;
                            fetch_pend_d = 1'b1;
                        end
                    end
                end
                TX_END: begin
                    tx_en_d    = 1'b0;
                    txd_d      = 4'h0;
                    frame_dec  = 1'b1;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IFG;
                end
                TX_IFG: begin
                    if (tx_cnt_q == IFG_LAST) tx_state_d = TX_IDLE;
                    else                      tx_cnt_d   = tx_cnt_q + C_ONE;
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + A_ONE;
    end

    // A commit and a completed transmission in the same cycle cancel out.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_inc && !frame_dec)      frame_cnt_d = frame_cnt_q + A_ONE;
        else if (frame_dec && !frame_inc) frame_cnt_d = frame_cnt_q - A_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_clk_sync_q    <= '0;
            rx_dv_sync_q     <= '0;
            rxd_s1_q         <= '0;
            rxd_s2_q         <= '0;
            tx_clk_sync_q    <= '0;
            rx_state_q       <= RX_IDLE;
            nib_lo_q         <= '0;
            nib_phase_q      <= 1'b0;
            rx_any_q         <= 1'b0;
            wr_tent_q        <= '0;
            wr_com_q         <= '0;
            data_from_phy_q  <= '0;
            tx_state_q       <= TX_IDLE;
            tx_cnt_q         <= '0;
            tx_hi_q          <= 1'b0;
            cur_last_q       <= 1'b0;
            fetch_pend_q     <= 1'b0;
            tx_en_q          <= 1'b0;
            txd_q            <= '0;
            rd_ptr_q         <= '0;
            data_from_buff_q <= '0;
            frame_cnt_q      <= '0;
        end else begin
            rx_clk_sync_q    <= rx_clk_sync_d;
            rx_dv_sync_q     <= rx_dv_sync_d;
            rxd_s1_q         <= rxd_s1_d;
            rxd_s2_q         <= rxd_s2_d;
            tx_clk_sync_q    <= tx_clk_sync_d;
            rx_state_q       <= rx_state_d;
            nib_lo_q         <= nib_lo_d;
            nib_phase_q      <= nib_phase_d;
            rx_any_q         <= rx_any_d;
            wr_tent_q        <= wr_tent_d;
            wr_com_q         <= wr_com_d;
            data_from_phy_q  <= data_from_phy_d;
            tx_state_q       <= tx_state_d;
            tx_cnt_q         <= tx_cnt_d;
            tx_hi_q          <= tx_hi_d;
            cur_last_q       <= cur_last_d;
            fetch_pend_q     <= fetch_pend_d;
            tx_en_q          <= tx_en_d;
            txd_q            <= txd_d;
            rd_ptr_q         <= rd_ptr_d;
            data_from_buff_q <= data_from_buff_d;
            frame_cnt_q      <= frame_cnt_d;
        end
    end

    // Storage array carries no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdat;
        if (rd_en)  rd_dat_q       <= mem[rd_ptr_q];
    end

    assign mii.phy_tx_en   = tx_en_q;
    assign mii.phy_txd     = txd_q;
    assign data_from_phy   = data_from_phy_q;
    assign data_from_buff  = data_from_buff_q;
endmodule

// File: tb/tb_mii_store_forward_bridge.sv
module tb_mii_store_forward_bridge;
    logic clk = 1'b0, reset = 1'b0, rx_clk = 1'b0, tx_clk = 1'b0;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;
    initial begin #3;  forever #40 rx_clk = ~rx_clk; end
    initial begin #21; forever #40 tx_clk = ~tx_clk; end

    mii_store_forward_bridge_if m0 ();
    mii_store_forward_bridge_if m1 ();
    assign m0.phy_rx_clk = rx_clk;
    assign m0.phy_tx_clk = tx_clk;
    assign m1.phy_rx_clk = rx_clk;
    assign m1.phy_tx_clk = tx_clk;

    logic [7:0] dfp0, dfb0, dfp1, dfb1;

    mii_store_forward_bridge #(.ADDR_W(11), .PRE_NIB(15), .IFG_NIB(24)) dut0 (
        .clk(clk), .reset(reset), .mii(m0), .data_from_phy(dfp0), .data_from_buff(dfb0));
    mii_store_forward_bridge #(.ADDR_W(4), .PRE_NIB(15), .IFG_NIB(24)) dut1 (
        .clk(clk), .reset(reset), .mii(m1), .data_from_phy(dfp1), .data_from_buff(dfb1));

    // TX monitor: records every nibble sent while tx_en=1, frame lengths, and idle gaps.
    logic       en_w  [2];
    logic [3:0] txd_w [2];
    logic [7:0] buf_w [2];
    assign en_w[0] = m0.phy_tx_en;  assign txd_w[0] = m0.phy_txd;  assign buf_w[0] = dfb0;
    assign en_w[1] = m1.phy_tx_en;  assign txd_w[1] = m1.phy_txd;  assign buf_w[1] = dfb1;

    logic [3:0] nibs  [2][$];
    logic [7:0] bufs  [2][$];
    int         flens [2][$];
    int         cur_len [2] = '{0, 0};
    int         idle_cnt[2] = '{0, 0};
    int         last_gap[2] = '{0, 0};
    logic       prev_en [2] = '{1'b0, 1'b0};
    logic       seen    [2] = '{1'b0, 1'b0};

    always @(negedge tx_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (en_w[k]) begin
                if (!prev_en[k]) begin
                    if (seen[k]) last_gap[k] = idle_cnt[k];
                    seen[k]    = 1'b1;
                    cur_len[k] = 0;
                end
                nibs[k].push_back(txd_w[k]);
                bufs[k].push_back(buf_w[k]);
                cur_len[k]++;
            end else begin
                if (prev_en[k]) begin
                    flens[k].push_back(cur_len[k]);
                    idle_cnt[k] = 0;
                end
                idle_cnt[k]++;
            end
            prev_en[k] = en_w[k];
        end
    end

    logic [7:0] fr[$];
    logic [7:0] hdr1 [14] = '{8'h12, 8'hd1, 8'h46, 8'h11, 8'h10, 8'h11, 8'h59,
                              8'hab, 8'hcd, 8'hef, 8'h11, 8'h22, 8'hab, 8'h12};
    logic [7:0] hdr2 [12] = '{8'hd2, 8'h34, 8'h56, 8'h78, 8'haa, 8'hbb,
                              8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] fcs1 [4]  = '{8'hde, 8'had, 8'hbe, 8'hef};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build1();
        fr.delete();
        for (int i = 0; i < 14; i++)  fr.push_back(hdr1[i]);
        for (int i = 0; i < 100; i++) fr.push_back(8'h19);
        for (int i = 0; i < 4; i++)   fr.push_back(fcs1[i]);
    endtask

    task automatic build2();
        fr.delete();
        for (int i = 0; i < 12; i++) fr.push_back(hdr2[i]);
        for (int i = 0; i < 99; i++) fr.push_back(8'((i * 3 + 1) & 255));
    endtask

    task automatic build_seq(input int n, input logic [7:0] base);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(base + 8'(i));
    endtask

    task automatic drive(input int which, input logic dv, input logic [3:0] nib);
        @(negedge rx_clk);
        if (which == 0) begin m0.phy_rx_dv = dv; m0.phy_rxd = nib; end
        else            begin m1.phy_rx_dv = dv; m1.phy_rxd = nib; end
    endtask

    // lim: number of leading bytes expected to appear on data_from_phy; later bytes hold the last one.
    task automatic send_frame(input int which, input logic bad_pre, input logic odd, input int lim);
        logic [7:0] obs;
        for (int i = 0; i < 15; i++) drive(which, 1'b1, (bad_pre && i == 7) ? 4'h3 : 4'h5);
        drive(which, 1'b1, 4'hD);
        for (int i = 0; i < fr.size(); i++) begin
            drive(which, 1'b1, fr[i][3:0]);
            drive(which, 1'b1, fr[i][7:4]);
            if (lim > 0) begin
                @(posedge rx_clk); #35;
                obs = (which == 0) ? dfp0 : dfp1;
                chk("rx_data_from_phy", 32'(obs), 32'(fr[(i < lim) ? i : lim - 1]));
            end
        end
        if (odd) drive(which, 1'b1, 4'h7);
        for (int i = 0; i < 12; i++) drive(which, 1'b0, 4'h0);
    endtask

    task automatic wait_frames(input int which, input int n);
        int t = 0;
        while (flens[which].size() < n && t < 30000) begin @(posedge clk); t++; end
        chk("tx_frames_seen", 32'(flens[which].size()), 32'(n));
    endtask

    task automatic pop_nib(input int which, output logic [3:0] nib, output logic [7:0] bv);
        nib = 4'hx; bv = 8'hxx;
        if (nibs[which].size() > 0) begin
            nib = nibs[which].pop_front();
            bv  = bufs[which].pop_front();
        end
    endtask

    task automatic check_frame(input int which);
        int         n;
        logic       ok;
        logic [3:0] lo, hi;
        logic [7:0] bl, bh;
        n = (flens[which].size() > 0) ? flens[which].pop_front() : -1;
        chk("tx_nibble_count", 32'(n), 32'(16 + 2 * fr.size()));
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            pop_nib(which, lo, bl);
            if (lo !== 4'h5) ok = 1'b0;
        end
        chk("tx_preamble", 32'(ok), 32'd1);
        pop_nib(which, lo, bl);
        chk("tx_sfd", 32'(lo), 32'hD);
        for (int i = 0; i < fr.size(); i++) begin
            pop_nib(which, lo, bl);
            pop_nib(which, hi, bh);
            chk("tx_byte", 32'({hi, lo}), 32'(fr[i]));
            chk("tx_data_from_buff", 32'(bl), 32'(fr[i]));
        end
    endtask

    initial begin
        logic [7:0] held;
        int         t;
        m0.phy_rx_dv = 1'b0; m0.phy_rxd = 4'h0;
        m1.phy_rx_dv = 1'b0; m1.phy_rxd = 4'h0;
        reset = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("reset_tx_en",   32'(m0.phy_tx_en), 32'd0);
        chk("reset_txd",     32'(m0.phy_txd),   32'd0);
        chk("reset_dfp",     32'(dfp0),         32'd0);
        chk("reset_dfb",     32'(dfb0),         32'd0);
        chk("reset_tx_en_s", 32'(m1.phy_tx_en), 32'd0);
        reset = 1'b1;
        repeat (4) @(posedge clk);

        // Single 118-byte frame
        build1(); send_frame(0, 1'b0, 1'b0, fr.size());
        wait_frames(0, 1);
        check_frame(0);

        // Two back-to-back frames
        build1(); send_frame(0, 1'b0, 1'b0, fr.size());
        build2(); send_frame(0, 1'b0, 1'b0, fr.size());
        held = fr[fr.size() - 1];
        wait_frames(0, 2);
        build1(); check_frame(0);
        build2(); check_frame(0);
        chk("ifg_at_least_24", 32'(last_gap[0] >= 24), 32'd1);

        // Bad preamble: nothing written, nothing sent
        build_seq(4, 8'h01);
        send_frame(0, 1'b1, 1'b0, 0);
        repeat (60) @(posedge tx_clk);
        chk("bad_pre_no_tx", 32'(nibs[0].size() + flens[0].size()), 32'd0);
        chk("bad_pre_dfp_held", 32'(dfp0), 32'(held));

        // Odd nibble count: trailing nibble discarded
        fr.delete(); fr.push_back(8'h3c); fr.push_back(8'ha5);
        send_frame(0, 1'b0, 1'b1, 2);
        wait_frames(0, 1);
        check_frame(0);
        chk("odd_no_extra", 32'(nibs[0].size()), 32'd0);

        // ADDR_W=4: 20-byte frame overflows after 15 bytes and is dropped whole
        build_seq(20, 8'h40);
        send_frame(1, 1'b0, 1'b0, 15);
        repeat (60) @(posedge tx_clk);
        chk("overflow_no_tx", 32'(nibs[1].size() + flens[1].size()), 32'd0);
        chk("overflow_dfp", 32'(dfp1), 32'h4e);
        build_seq(8, 8'h80);
        send_frame(1, 1'b0, 1'b0, 8);
        wait_frames(1, 1);
        check_frame(1);

        // Reset in the middle of transmission
        build1(); send_frame(0, 1'b0, 1'b0, fr.size());
        t = 0;
        while (nibs[0].size() < 60 && t < 30000) begin @(posedge clk); t++; end
        chk("tx_started", 32'(nibs[0].size() >= 60), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("midreset_tx_en", 32'(m0.phy_tx_en), 32'd0);
        chk("midreset_txd",   32'(m0.phy_txd),   32'd0);
        chk("midreset_dfp",   32'(dfp0),         32'd0);
        chk("midreset_dfb",   32'(dfb0),         32'd0);
        repeat (3) @(posedge tx_clk);
        nibs[0].delete(); bufs[0].delete(); flens[0].delete();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        build_seq(8, 8'hc3);
        send_frame(0, 1'b0, 1'b0, 8);
        wait_frames(0, 1);
        check_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
